crossbar_nxm: RTL and testbench
===============================

// Module: crossbar_nxm
// PURPOSE
//  Parametrised N-master x M-slave request/ack crossbar; successor to the fixed 2x2 crossbar.
//  Routes each master transaction to the slave selected by the top address bits.
//  Arbitrates per slave with a round-robin pointer.
//  Sits between CPU/DMA masters and memory/peripheral slaves; one outstanding transaction per master.
// PARAMETERS
//  N_MASTERS  2   number of masters (>=2)
//  N_SLAVES   2   number of slaves, power of two (>=2); SEL_W = $clog2(N_SLAVES)
//  AW         32  address width; slave index = addr[AW-1 -: SEL_W]
//  DW         32  data width
//  TIMEOUT    16  ack watchdog limit in cycles (used only with XBAR_TIMEOUT_EN)
// PORTS
//  clk            in   1             clock, rising edge
//  reset          in   1             synchronous, active-low reset
//  master_req     in   N_MASTERS     per-master request
//  master_cmd     in   N_MASTERS     per-master command: 1=write, 0=read
//  master_addr    in   N_MASTERS*AW  flattened addresses, master i at [i*AW +: AW]
//  master_wdata   in   N_MASTERS*DW  flattened write data
//  master_rdata   out  N_MASTERS*DW  flattened read data, valid with master_ack
//  master_ack     out  N_MASTERS     one-cycle completion pulse
//  master_err     out  N_MASTERS     one-cycle timeout pulse; tied 0 without XBAR_TIMEOUT_EN
//  slave_req      out  N_SLAVES      per-slave request
//  slave_cmd      out  N_SLAVES      forwarded command
//  slave_addr     out  N_SLAVES*AW   forwarded address
//  slave_wdata    out  N_SLAVES*DW   forwarded write data
//  slave_rdata    in   N_SLAVES*DW   slave read data, sampled with slave_ack
//  slave_ack      in   N_SLAVES      slave completion
// BEHAVIOUR
//  Reset (reset==0 at a rising edge):
//   - every slave FSM goes to IDLE; every RR pointer to 0.
//   - all outputs go to 0; an in-flight transaction is dropped with no ack.
//  Per-slave FSM, IDLE -> BUSY -> IDLE:
//   - IDLE: among masters with req=1 addressing this slave, grant the first at or after the
//     pointer, searching upward mod N_MASTERS. On the edge: register grant index; drive
//     slave_req=1 and cmd/addr/wdata of the winner; go BUSY; pointer = winner+1 mod N_MASTERS.
//   - BUSY: cmd/addr/wdata track the granted master, which must hold them stable.
//     slave_ack=1 at an edge -> master_ack[g]=1 for exactly the next cycle;
//     master_rdata[g] = slave_rdata on a read, unchanged on a write; slave_req=0; go IDLE.
//   - Latency: req at edge t -> slave_req high after t; ack at edge k -> master_ack high after k.
//     One idle cycle separates back-to-back grants on the same slave.
//  Master protocol:
//   - Master drops req in the cycle master_ack is seen.
//   - req still high at the following edge is a new transaction.
//  Boundaries:
//   - slave_ack while IDLE is ignored.
//   - Different slaves run fully in parallel; two masters hitting two slaves are granted on the same edge.
//   - Same-slave contention: the loser keeps waiting; it is never dropped.
//   - Pointer wraps from N_MASTERS-1 to 0.
// CONFIGURATION
//  `XBAR_TIMEOUT_EN defined:
//   - per-slave counter clears on grant and increments each BUSY cycle without ack.
//   - Reaching TIMEOUT: FSM goes IDLE; master_ack[g]=1 and master_err[g]=1 for one cycle;
//     master_rdata[g] = {DW{1'b1}}; a late slave_ack is ignored.
//   - An ack on the same edge as the limit wins: normal completion.
//  Undefined: no counter; BUSY waits indefinitely; master_err constant 0.
// STRUCTURE
//  Shared header crossbar_defs.vh:
//   - CMD_READ/CMD_WRITE constants, FSM state encodings, and the error read pattern.
//  Sub-module rr_arbiter (N requests, pointer in, one-hot grant out and index):
//   - instantiated N_SLAVES times.
//  Top handles address decode, grant muxing, ack/rdata demux and the optional watchdog.
// TESTING
//  T1: after reset, M0 read and M1 write to S0 in the same cycle ->
//      M0 granted first (slave_addr=32'h000add0); ack_s0 -> master_ack[0] pulse,
//      rdata_m0=32'hfeed00c0; then M1 granted with wdata 32'h000feed1.
//  T2: M0 to S1 (addr 32'h8000add0) while M1 to S0 -> both slave_req high on the same edge.
//  T3: M0 and M1 repeatedly request S0 with reqs held -> grants alternate 0,1,0,1
//      (pointer wrap checked).
//  T4: reset low while S0 BUSY -> next cycle all outputs 0; no master_ack.
//      After release, a new M1 request is granted before M0 (pointer=0, M0 idle).
//  T5 (XBAR_TIMEOUT_EN, TIMEOUT=16): S1 never acks ->
//      master_ack and master_err pulse 16 cycles after grant, rdata=32'hffffffff;
//      a later ack_s1 is ignored.
//  T6: slave_ack pulsed with no request outstanding -> no master_ack and no state change.

Source files
------------

// File: rtl/crossbar_nxm_pkg.sv
// Shared definitions for the N x M request/ack crossbar: command encodings and
// the per-slave transaction state.
package crossbar_nxm_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } slv_state_e;

endpackage

// File: rtl/crossbar_nxm_rr_arbiter.sv
// Round-robin request picker: grants the first requester at or after ptr_i,
// searching upward and wrapping modulo N. Purely combinational.
module crossbar_nxm_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [IW:0] cand;

  // Scan from the farthest offset down to the pointer so the last hit is the winner.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (IW + 1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req_i[cand[IW-1:0]]) begin
        idx_o   = cand[IW-1:0];
        valid_o = 1'b1;
      end
    end
    if (valid_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/crossbar_nxm.sv
// N-master x M-slave request/ack crossbar with per-slave round-robin arbitration.
// Optional ack watchdog enabled by defining XBAR_TIMEOUT_EN.
module crossbar_nxm
  import crossbar_nxm_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS-1:0]    master_req,
  input  logic [N_MASTERS-1:0]    master_cmd,
  input  logic [N_MASTERS*AW-1:0] master_addr,
  input  logic [N_MASTERS*DW-1:0] master_wdata,
  output logic [N_MASTERS*DW-1:0] master_rdata,
  output logic [N_MASTERS-1:0]    master_ack,
  output logic [N_MASTERS-1:0]    master_err,
  output logic [N_SLAVES-1:0]     slave_req,
  output logic [N_SLAVES-1:0]     slave_cmd,
  output logic [N_SLAVES*AW-1:0]  slave_addr,
  output logic [N_SLAVES*DW-1:0]  slave_wdata,
  input  logic [N_SLAVES*DW-1:0]  slave_rdata,
  input  logic [N_SLAVES-1:0]     slave_ack
);

  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int MIW   = $clog2(N_MASTERS);

  logic [AW-1:0]    m_addr  [N_MASTERS];
  logic [DW-1:0]    m_wdata [N_MASTERS];
  logic [SEL_W-1:0] m_sel   [N_MASTERS];
  logic [MIW-1:0]   s_gnt   [N_SLAVES];
  logic [DW-1:0]    s_rdata [N_SLAVES];
  logic [N_SLAVES-1:0] fin;
  logic [N_SLAVES-1:0] tmo;

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack_m
    assign m_addr[gi]  = master_addr[gi*AW +: AW];
    assign m_wdata[gi] = master_wdata[gi*DW +: DW];
    assign m_sel[gi]   = master_addr[gi*AW + AW - 1 -: SEL_W];
  end

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
    slv_state_e            state_q;
    logic [MIW-1:0]        gnt_q;
    logic [MIW-1:0]        ptr_q;
    logic [MIW-1:0]        ptr_d;
    logic                  req_q;
    logic                  cmd_q;
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         wdata_q;
    logic [N_MASTERS-1:0]  req_vec;
    logic [N_MASTERS-1:0]  arb_onehot;
    logic [MIW-1:0]        arb_idx;
    logic                  arb_valid;
    logic                  win_cmd;
    logic [AW-1:0]         win_addr;
    logic [DW-1:0]         win_wdata;

    always_comb begin
      req_vec = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        req_vec[i] = master_req[i] && (m_sel[i] == SEL_W'(gi));
      end
    end

    crossbar_nxm_rr_arbiter #(
      .N (N_MASTERS)
    ) u_arb (
      .req_i   (req_vec),
      .ptr_i   (ptr_q),
      .grant_o (arb_onehot),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
    );

    // One-hot AND-OR select of the winning master's request fields.
    always_comb begin
      win_cmd   = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (arb_onehot[i]) begin
          win_cmd   = win_cmd | master_cmd[i];
          win_addr  = win_addr | m_addr[i];
          win_wdata = win_wdata | m_wdata[i];
        end
      end
    end

    assign ptr_d = (arb_idx == MIW'(N_MASTERS - 1)) ? '0 : arb_idx + 1'b1;

`ifdef XBAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    // An ack arriving on the limit edge takes priority over the timeout.
    assign tmo[gi] = (state_q == ST_BUSY) && !slave_ack[gi] && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else if (!slave_ack[gi]) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
`else
    assign tmo[gi] = 1'b0;
`endif

    assign fin[gi] = (state_q == ST_BUSY) && (slave_ack[gi] || tmo[gi]);

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        gnt_q   <= '0;
        ptr_q   <= '0;
        req_q   <= 1'b0;
        cmd_q   <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arb_valid) begin
              state_q <= ST_BUSY;
              gnt_q   <= arb_idx;
              ptr_q   <= ptr_d;
              req_q   <= 1'b1;
              cmd_q   <= win_cmd;
              addr_q  <= win_addr;
              wdata_q <= win_wdata;
            end
          end
          ST_BUSY: begin
            cmd_q   <= master_cmd[gnt_q];
            addr_q  <= m_addr[gnt_q];
            wdata_q <= m_wdata[gnt_q];
            if (fin[gi]) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign s_gnt[gi]                  = gnt_q;
    assign s_rdata[gi]                = slave_rdata[gi*DW +: DW];
    assign slave_req[gi]              = req_q;
    assign slave_cmd[gi]              = cmd_q;
    assign slave_addr[gi*AW +: AW]    = addr_q;
    assign slave_wdata[gi*DW +: DW]   = wdata_q;
  end

  // A master has at most one transaction outstanding, so at most one slave completes for it.
  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    logic          ack_q;
    logic          ack_d;
    logic          err_q;
    logic          err_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      for (int s = 0; s < N_SLAVES; s++) begin
        if (fin[s] && (s_gnt[s] == MIW'(gi))) begin
          ack_d = 1'b1;
          if (tmo[s]) begin
            err_d   = 1'b1;
            rdata_d = '1;
          end else if (slave_cmd[s] == CMD_READ) begin
            rdata_d = s_rdata[s];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q   <= ack_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end

    assign master_ack[gi]             = ack_q;
    assign master_err[gi]             = err_q;
    assign master_rdata[gi*DW +: DW]  = rdata_q;
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// Self-checking bench for crossbar_nxm: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_crossbar_nxm;
  import crossbar_nxm_pkg::*;

  localparam int NM   = 2;
  localparam int NS   = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int SELW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     master_req;
  logic [NM-1:0]     master_cmd;
  logic [NM*AW-1:0]  master_addr;
  logic [NM*DW-1:0]  master_wdata;
  logic [NM*DW-1:0]  master_rdata;
  logic [NM-1:0]     master_ack;
  logic [NM-1:0]     master_err;
  logic [NS-1:0]     slave_req;
  logic [NS-1:0]     slave_cmd;
  logic [NS*AW-1:0]  slave_addr;
  logic [NS*DW-1:0]  slave_wdata;
  logic [NS*DW-1:0]  slave_rdata;
  logic [NS-1:0]     slave_ack;

  crossbar_nxm #(
    .N_MASTERS (NM),
    .N_SLAVES  (NS),
    .AW        (AW),
    .DW        (DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .master_req   (master_req),
    .master_cmd   (master_cmd),
    .master_addr  (master_addr),
    .master_wdata (master_wdata),
    .master_rdata (master_rdata),
    .master_ack   (master_ack),
    .master_err   (master_err),
    .slave_req    (slave_req),
    .slave_cmd    (slave_cmd),
    .slave_addr   (slave_addr),
    .slave_wdata  (slave_wdata),
    .slave_rdata  (slave_rdata),
    .slave_ack    (slave_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which master owns each slave (-1 = free), RR pointer, busy cycles.
  int            own [NS];
  int            ptr [NS];
  int            cnt [NS];
  logic          exp_sreq   [NS];
  logic          exp_scmd   [NS];
  logic [AW-1:0] exp_saddr  [NS];
  logic [DW-1:0] exp_swdata [NS];
  logic          exp_mack   [NM];
  logic          exp_merr   [NM];
  logic [DW-1:0] exp_mrdata [NM];
  bit            m_active   [NM];
  bit            rand_start;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int dest(input int m);
    logic [AW-1:0] a;
    a = master_addr[m*AW +: AW];
    return int'(a[AW-1 -: SELW]);
  endfunction

  task automatic load_fields(input int s, input int m);
    exp_sreq[s]   = 1'b1;
    exp_scmd[s]   = master_cmd[m];
    exp_saddr[s]  = master_addr[m*AW +: AW];
    exp_swdata[s] = master_wdata[m*DW +: DW];
  endtask

  task automatic complete(input int s, input bit err);
    int g;
    g = own[s];
    exp_mack[g] = 1'b1;
    exp_merr[g] = err;
    if (err) exp_mrdata[g] = '1;
    else if (master_cmd[g] == CMD_READ) exp_mrdata[g] = slave_rdata[s*DW +: DW];
    own[s] = -1;
    exp_sreq[s] = 1'b0;
    $display("txn master=%0d slave=%0d cmd=%0d err=%0d rdata=%08h", g, s, master_cmd[g], err, exp_mrdata[g]);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int m = 0; m < NM; m++) begin
      exp_mack[m] = 1'b0;
      exp_merr[m] = 1'b0;
    end
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        own[s] = -1; ptr[s] = 0; cnt[s] = 0;
        exp_sreq[s] = 1'b0; exp_scmd[s] = 1'b0; exp_saddr[s] = '0; exp_swdata[s] = '0;
      end
      for (int m = 0; m < NM; m++) exp_mrdata[m] = '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (own[s] < 0) begin
          for (int k = 0; k < NM; k++) begin
            int m;
            m = (ptr[s] + k) % NM;
            if (own[s] < 0 && master_req[m] && dest(m) == s) begin
              own[s] = m;
              ptr[s] = (m + 1) % NM;
              cnt[s] = 0;
              load_fields(s, m);
            end
          end
        end else begin
          load_fields(s, own[s]);
          if (slave_ack[s]) complete(s, 1'b0);
`ifdef XBAR_TIMEOUT_EN
          else if (cnt[s] + 1 >= TMO) complete(s, 1'b1);
          else cnt[s]++;
`endif
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < NM; m++) begin
      check($sformatf("m%0d_ack", m), 64'(master_ack[m]), 64'(exp_mack[m]));
      check($sformatf("m%0d_err", m), 64'(master_err[m]), 64'(exp_merr[m]));
      check($sformatf("m%0d_rdata", m), 64'(master_rdata[m*DW +: DW]), 64'(exp_mrdata[m]));
    end
    for (int s = 0; s < NS; s++) begin
      check($sformatf("s%0d_req", s), 64'(slave_req[s]), 64'(exp_sreq[s]));
      if (exp_sreq[s]) begin
        check($sformatf("s%0d_cmd", s), 64'(slave_cmd[s]), 64'(exp_scmd[s]));
        check($sformatf("s%0d_addr", s), 64'(slave_addr[s*AW +: AW]), 64'(exp_saddr[s]));
        check($sformatf("s%0d_wdata", s), 64'(slave_wdata[s*DW +: DW]), 64'(exp_swdata[s]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_m(input int m, input logic req, input logic cmd,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    master_req[m]             = req;
    master_cmd[m]             = cmd;
    master_addr[m*AW +: AW]   = a;
    master_wdata[m*DW +: DW]  = wd;
  endtask

  function automatic bit any_active();
    bit r;
    r = 1'b0;
    for (int m = 0; m < NM; m++) r = r | m_active[m];
    return r;
  endfunction

  // Random masters obey the protocol (drop req on ack); random slaves ack late or spuriously.
  task automatic drive_random();
    for (int m = 0; m < NM; m++) begin
      if (m_active[m]) begin
        if (exp_mack[m]) begin
          master_req[m] = 1'b0;
          m_active[m]   = 1'b0;
        end
      end else if (rand_start && $urandom_range(0, 3) == 0) begin
        logic [AW-1:0] a;
        a = $urandom();
        a[AW-1 -: SELW] = SELW'($urandom_range(0, NS - 1));
        set_m(m, 1'b1, 1'($urandom_range(0, 1)), a, $urandom());
        m_active[m] = 1'b1;
      end
    end
    for (int s = 0; s < NS; s++) begin
      slave_ack[s] = 1'b0;
      if ((exp_sreq[s] && $urandom_range(0, 2) == 0) || (!exp_sreq[s] && $urandom_range(0, 5) == 0)) begin
        slave_ack[s] = 1'b1;
        slave_rdata[s*DW +: DW] = $urandom();
      end
    end
  endtask

  initial begin
    int w;
    reset        = 1'b0;
    master_req   = '0;
    master_cmd   = '0;
    master_addr  = '0;
    master_wdata = '0;
    slave_rdata  = '0;
    slave_ack    = '0;
    rand_start   = 1'b0;
    for (int m = 0; m < NM; m++) m_active[m] = 1'b0;
    step();
    step();
    check("reset_sreq", 64'(slave_req), 64'(0));
    check("reset_mack", 64'(master_ack), 64'(0));
    reset = 1'b1;
    step();

    // T1: same-slave contention, M0 read wins, then M1 write after one idle cycle.
    set_m(0, 1'b1, CMD_READ, 32'h000add0, 32'h0);
    set_m(1, 1'b1, CMD_WRITE, 32'h000add1, 32'h000feed1);
    step();
    check("t1_grant_req", 64'(slave_req[0]), 64'(1));
    check("t1_grant_addr", 64'(slave_addr[0 +: AW]), 64'(32'h000add0));
    slave_ack[0] = 1'b1;
    slave_rdata[0 +: DW] = 32'hfeed00c0;
    step();
    slave_ack[0] = 1'b0;
    check("t1_m0_ack", 64'(master_ack), 64'(2'b01));
    check("t1_m0_rdata", 64'(master_rdata[0 +: DW]), 64'(32'hfeed00c0));
    check("t1_idle_gap", 64'(slave_req[0]), 64'(0));
    master_req[0] = 1'b0;
    step();
    check("t1_m1_grant", 64'(slave_req[0]), 64'(1));
    check("t1_m1_wdata", 64'(slave_wdata[0 +: DW]), 64'(32'h000feed1));
    slave_ack[0] = 1'b1;
    step();
    slave_ack[0] = 1'b0;
    check("t1_m1_ack", 64'(master_ack), 64'(2'b10));
    check("t1_m1_rdata_kept", 64'(master_rdata[DW +: DW]), 64'(0));
    master_req[1] = 1'b0;
    step();

    // T2: two masters on two slaves are granted on the same edge.
    set_m(0, 1'b1, CMD_READ, 32'h8000add0, 32'h0);
    set_m(1, 1'b1, CMD_READ, 32'h0000add4, 32'h0);
    step();
    check("t2_parallel_req", 64'(slave_req), 64'(2'b11));
    check("t2_s1_addr", 64'(slave_addr[AW +: AW]), 64'(32'h8000add0));
    slave_ack = 2'b11;
    slave_rdata = {32'h5151a1a1, 32'h5050b0b0};
    step();
    slave_ack = 2'b00;
    check("t2_both_ack", 64'(master_ack), 64'(2'b11));
    check("t2_m0_rdata", 64'(master_rdata[0 +: DW]), 64'(32'h5151a1a1));
    check("t2_m1_rdata", 64'(master_rdata[DW +: DW]), 64'(32'h5050b0b0));
    master_req = 2'b00;
    step();

    // T3: held requests on S0 alternate M0,M1,M0,M1,M0 through the pointer wrap.
    set_m(0, 1'b1, CMD_WRITE, 32'h00000a00, 32'h0a0a0a0a);
    set_m(1, 1'b1, CMD_WRITE, 32'h00000a04, 32'h1b1b1b1b);
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (!slave_req[0] && w < 8) begin
        step();
        w++;
      end
      check($sformatf("t3_grant%0d_addr", g), 64'(slave_addr[0 +: AW]),
            64'((g % 2 == 0) ? 32'h00000a00 : 32'h00000a04));
      slave_ack[0] = 1'b1;
      step();
      slave_ack[0] = 1'b0;
      if (g == 3) master_req[1] = 1'b0;
      if (g == 4) master_req[0] = 1'b0;
    end
    step();

    // T6: a stray slave ack with nothing outstanding is ignored.
    slave_ack = 2'b11;
    step();
    slave_ack = 2'b00;
    check("t6_no_ack", 64'(master_ack), 64'(0));
    check("t6_no_req", 64'(slave_req), 64'(0));
    step();

    // T4: reset while S0 is busy drops the transaction; afterwards M1 is served first.
    set_m(0, 1'b1, CMD_READ, 32'h00000c00, 32'h0);
    step();
    check("t4_busy", 64'(slave_req[0]), 64'(1));
    reset = 1'b0;
    master_req[0] = 1'b0;
    step();
    check("t4_rst_sreq", 64'(slave_req), 64'(0));
    check("t4_rst_mack", 64'(master_ack), 64'(0));
    check("t4_rst_addr", slave_addr, 64'(0));
    check("t4_rst_rdata", master_rdata, 64'(0));
    reset = 1'b1;
    set_m(1, 1'b1, CMD_READ, 32'h00000c04, 32'h0);
    step();
    check("t4_m1_grant", 64'(slave_addr[0 +: AW]), 64'(32'h00000c04));
    slave_ack[0] = 1'b1;
    step();
    slave_ack[0] = 1'b0;
    master_req[1] = 1'b0;
    step();

`ifdef XBAR_TIMEOUT_EN
    // T5: S1 never acks; watchdog completes with error after TMO cycles.
    set_m(0, 1'b1, CMD_READ, 32'h80000100, 32'h0);
    step();
    w = 0;
    while (!master_ack[0] && w < 40) begin
      step();
      w++;
    end
    check("t5_latency", 64'(w), 64'(TMO));
    check("t5_err", 64'(master_err[0]), 64'(1));
    check("t5_rdata", 64'(master_rdata[0 +: DW]), 64'(32'hffffffff));
    master_req[0] = 1'b0;
    step();
    slave_ack[1] = 1'b1;
    step();
    slave_ack[1] = 1'b0;
    check("t5_late_ack", 64'(master_ack), 64'(0));
    step();
`endif

    // Randomized traffic, then drain all outstanding transactions.
    rand_start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end
    rand_start = 1'b0;
    w = 0;
    while (any_active() && w < 400) begin
      drive_random();
      step();
      w++;
    end
    slave_ack = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
